// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - RV32I decoded control word, its mux/op encodings and the NOP_CTRL bubble value
package rv32i_types;

  typedef enum logic [2:0] {
    immmux_i_imm = 3'd0, immmux_u_imm, immmux_b_imm, immmux_s_imm, immmux_j_imm
  } immmux_sel_t;

  typedef enum logic {alumux1_rs1_out = 1'b0, alumux1_pc_out} alumux1_sel_t;
  typedef enum logic {alumux2_imm = 1'b0, alumux2_rs2_out} alumux2_sel_t;

  typedef enum logic [3:0] {
    regfilemux_alu_out = 4'd0, regfilemux_br_en, regfilemux_u_imm, regfilemux_lw,
    regfilemux_pc_plus4, regfilemux_lb, regfilemux_lbu, regfilemux_lh, regfilemux_lhu
  } regfilemux_sel_t;

  typedef enum logic [1:0] {pcmux_pc_plus4 = 2'd0, pcmux_alu_out, pcmux_alu_mod2} pcmux_sel_t;
  typedef enum logic {cmpmux_i_imm = 1'b0, cmpmux_rs2_out} cmpmux_sel_t;

  typedef enum logic [2:0] {
    alu_add = 3'd0, alu_sll, alu_sra, alu_sub, alu_xor, alu_srl, alu_or, alu_and
  } alu_ops_t;

  typedef enum logic [2:0] {
    cmp_beq = 3'b000, cmp_bne = 3'b001, cmp_blt = 3'b100,
    cmp_bge = 3'b101, cmp_bltu = 3'b110, cmp_bgeu = 3'b111
  } branch_funct3_t;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    alu_ops_t        aluop;
    branch_funct3_t  cmpop;
    immmux_sel_t     immmux;
    alumux1_sel_t    alumux1;
    alumux2_sel_t    alumux2;
    regfilemux_sel_t regfilemux;
    pcmux_sel_t      pcmux;
    cmpmux_sel_t     cmpmux;
    logic            mem_read;
    logic            mem_write;
    logic            mem_op;
    logic            jmp_op;
    logic            br_op;
    logic            load_regfile;
    logic            commit;
    logic            multiplier_start;
    logic            divider_start;
    logic            rd_valid;
  } rv32i_ctrl_word;

  // addi x0, x0, 0 with every side-effect flag cleared: safe bubble
  localparam rv32i_ctrl_word NOP_CTRL = '{
    opcode: 7'b0010011, funct3: 3'b000, aluop: alu_add, cmpop: cmp_beq,
    immmux: immmux_i_imm, alumux1: alumux1_rs1_out, alumux2: alumux2_imm,
    regfilemux: regfilemux_alu_out, pcmux: pcmux_pc_plus4, cmpmux: cmpmux_i_imm,
    mem_read: 1'b0, mem_write: 1'b0, mem_op: 1'b0, jmp_op: 1'b0, br_op: 1'b0,
    load_regfile: 1'b0, commit: 1'b0, multiplier_start: 1'b0,
    divider_start: 1'b0, rd_valid: 1'b0
  };

endpackage

// File: rtl/ctrl_pipe_entry.sv
// rtl/ctrl_pipe_entry.sv - one pipeline slot: valid bit, control word and payload with load/clear
module ctrl_pipe_entry
  import rv32i_types::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load,
  input  rv32i_ctrl_word      ld_ctrl,
  input  logic [DATA_W-1:0]   ld_data,
  output logic                valid,
  output rv32i_ctrl_word      ctrl,
  output logic [DATA_W-1:0]   data
);

  // An empty slot always shows the bubble so downstream never sees stale fields
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      ctrl  <= NOP_CTRL;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
      data  <= ld_data;
    end
  end

endmodule

// File: rtl/ctrl_pipe_stage.sv
// rtl/ctrl_pipe_stage.sv - valid/ready control-word pipeline stage with stall counter; CTRL_PIPE_SKID_EN adds a skid slot
module ctrl_pipe_stage
  import rv32i_types::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  rv32i_ctrl_word      in_ctrl,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output rv32i_ctrl_word      out_ctrl,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          occ,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic              accept, consume;
  logic              main_valid, main_load, main_clear;
  rv32i_ctrl_word    main_ld_ctrl;
  logic [DATA_W-1:0] main_ld_data;

  assign accept  = in_valid && in_ready;
  assign consume = main_valid && out_ready;

`ifdef CTRL_PIPE_SKID_EN
  logic              skid_valid, skid_load, skid_clear;
  rv32i_ctrl_word    skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // skid_valid is a flop, so in_ready never depends on out_ready
  assign in_ready     = !skid_valid;
  assign main_load    = !flush && (skid_valid ? consume : (accept && (!main_valid || consume)));
  assign main_clear   = flush || (consume && !main_load);
  assign main_ld_ctrl = skid_valid ? skid_ctrl : in_ctrl;
  assign main_ld_data = skid_valid ? skid_data : in_data;
  assign skid_load    = !flush && accept && main_valid && !consume;
  assign skid_clear   = flush || (skid_valid && consume);
  assign occ          = {1'b0, main_valid} + {1'b0, skid_valid};

  ctrl_pipe_entry #(.DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clear   (skid_clear),
    .load    (skid_load),
    .ld_ctrl (in_ctrl),
    .ld_data (in_data),
    .valid   (skid_valid),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );
`else
  assign in_ready     = !main_valid || out_ready;
  assign main_load    = !flush && accept;
  assign main_clear   = flush || (consume && !accept);
  assign main_ld_ctrl = in_ctrl;
  assign main_ld_data = in_data;
  assign occ          = {1'b0, main_valid};
`endif

  ctrl_pipe_entry #(.DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .clear   (main_clear),
    .load    (main_load),
    .ld_ctrl (main_ld_ctrl),
    .ld_data (main_ld_data),
    .valid   (main_valid),
    .ctrl    (out_ctrl),
    .data    (out_data)
  );

  assign out_valid = main_valid;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// tb/tb_ctrl_pipe_stage.sv - scoreboard bench for ctrl_pipe_stage (either CTRL_PIPE_SKID_EN build)
module tb_ctrl_pipe_stage;
  import rv32i_types::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
`ifdef CTRL_PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam int CW = $bits(rv32i_ctrl_word);

  typedef struct {
    rv32i_ctrl_word    c;
    logic [DATA_W-1:0] d;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, out_ready;
  logic              in_ready, out_valid;
  rv32i_ctrl_word    in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  stall_cnt;

  entry_t exp_q[$];
  int     exp_stall = 0;
  int     checks = 0;
  int     errors = 0;
  bit     mon_en = 1'b0;

  always #5 clk = ~clk;

  ctrl_pipe_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occ       (occ),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: compares the visible stage against the in-order queue, pops on consume
  always @(negedge clk) begin
    int   n;
    logic exp_ir;
    if (mon_en) begin
      n = exp_q.size();
      exp_ir = (CAP == 2) ? (n < 2) : (n == 0 || out_ready);
      check("in_ready", in_ready, exp_ir);
      check("occ", occ, n);
      check("out_valid", out_valid, n > 0);
      check("stall_cnt", stall_cnt, exp_stall);
      if (n > 0) begin
        check("out_data", out_data, exp_q[0].d);
        check("out_ctrl", out_ctrl, exp_q[0].c);
        if (out_ready) void'(exp_q.pop_front());
        else if (exp_stall < (1 << CNT_W) - 1) exp_stall++;
      end else begin
        check("idle_data", out_data, 0);
        check("idle_ctrl", out_ctrl, NOP_CTRL);
      end
    end
  end

  // One cycle of stimulus; expected entries are queued after the monitor has run
  task automatic step(input bit iv, input logic [DATA_W-1:0] d, input bit ordy,
                      input bit fl, input bit r);
    logic [CW-1:0] v;
    bit            acc;
    entry_t        e;
    v = CW'({$urandom, $urandom});
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = v;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    acc = iv && ((CAP == 2) ? (exp_q.size() < 2) : (exp_q.size() == 0 || ordy));
    e.c = v;
    e.d = d;
    @(negedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      exp_stall = 0;
    end else if (fl) begin
      exp_q.delete();
    end else if (acc) begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = NOP_CTRL; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_occ", occ, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_ctrl", out_ctrl, NOP_CTRL);
    check("rst_stall", stall_cnt, 0);
    mon_en = 1'b1;

    // in-order streaming at full rate
    for (int i = 1; i <= 8; i++) step(1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // back-pressure: second entry lands in skid (or is refused without it)
    step(1'b1, 'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 'hB, 1'b0, 1'b0, 1'b0);
    check("bp_occ", occ, CAP);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // flush with a same-cycle accept
    step(1'b1, 'h1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 'h2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 'hC, 1'b0, 1'b1, 1'b0);
    check("flush_occ", occ, 0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // stall counter saturation
    step(1'b1, 'h5, 1'b0, 1'b0, 1'b0);
    repeat ((1 << CNT_W) + 5) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("stall_sat", stall_cnt, 15);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("stall_hold", stall_cnt, 15);

    // accept and consume in the same cycle while occupied
    step(1'b1, 'h7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 'h8, 1'b0, 1'b0, 1'b0);
    step(1'b1, 'h9, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // reset mid-transfer
    step(1'b1, 'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 'h12, 1'b0, 1'b0, 1'b0);
    step(1'b1, 'h13, 1'b1, 1'b0, 1'b1);
    check("midrst_occ", occ, 0);
    check("midrst_stall", stall_cnt, 0);

    for (int i = 0; i < 600; i++)
      step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
           ($urandom % 25) == 0, ($urandom % 60) == 0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_stage.md
CTRL_PIPE_STAGE -- requirements
Module: ctrl_pipe_stage

Interface
- REQ-001: Parameter DATA_W, default 32, width of the data payload carried alongside the control word.
- REQ-002: Parameter CNT_W, default 16, width of the stall counter.
- REQ-003: Port clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-004: Port rst, input, 1, synchronous active-high reset sampled on the rising edge of clk.
- REQ-005: Port flush, input, 1, synchronous invalidate of all held entries.
- REQ-006: Port in_valid, input, 1, upstream entry present.
- REQ-007: Port in_ready, output, 1, stage accepts an entry this cycle.
- REQ-008: Port in_ctrl, input, rv32i_ctrl_word, upstream control word.
- REQ-009: Port in_data, input, DATA_W, upstream payload.
- REQ-010: Port out_valid, output, 1, downstream entry present.
- REQ-011: Port out_ready, input, 1, downstream consumes this cycle.
- REQ-012: Port out_ctrl, output, rv32i_ctrl_word, head control word.
- REQ-013: Port out_data, output, DATA_W, head payload.
- REQ-014: Port occ, output, 2, number of valid entries held (0..2).
- REQ-015: Port stall_cnt, output, CNT_W, cycles with out_valid=1 and out_ready=0.

Function
- REQ-016: Accept occurs when in_valid && in_ready; consume occurs when out_valid && out_ready.
- REQ-017: An accepted entry appears on out_* exactly 1 cycle after acceptance when the stage was empty.
- REQ-018: Entries leave in acceptance order; no entry is duplicated or lost except by flush or rst.
- REQ-019: When out_valid=0, out_ctrl equals NOP_CTRL and out_data equals 0.
- REQ-020: NOP_CTRL: mem_read, mem_write, mem_op, jmp_op, br_op, load_regfile, commit, multiplier_start, divider_start, rd_valid all 0; immmux i_imm, alumux1 rs1_out, alumux2 imm, regfilemux alu_out, pcmux pc_plus4, cmpmux i_imm, aluop alu_add, cmpop beq, opcode 7'b0010011, funct3 0.
- REQ-021: Flush asserted in a cycle: next cycle occ=0, out_valid=0; any accept in that same cycle is discarded; any consume in that cycle still counts as consumed downstream.
- REQ-022: rst has priority over flush; flush has priority over accept.
- REQ-023: Simultaneous accept and consume with occ=1 keeps occ=1 and the new entry becomes head next cycle (full throughput).
- REQ-024: stall_cnt increments by 1 each cycle with out_valid && !out_ready, saturates at all-ones, unaffected by flush.
- REQ-025: occ never exceeds the configured capacity; accept while full is impossible because in_ready=0.

Reset
- REQ-026: On rst: occ=0, out_valid=0, out_ctrl=NOP_CTRL, out_data=0, stall_cnt=0, held entries invalidated.
- REQ-027: in_ready in the cycle after rst: 1.
- REQ-028: rst asserted mid-transfer discards all held entries; no partial state survives.

Configuration
- REQ-029: Macro CTRL_PIPE_SKID_EN defined: capacity 2 (main + skid register); in_ready = (occ<2) registered, independent of out_ready; entry accepted while main is stalled goes to skid; skid moves to main on consume.
- REQ-030: CTRL_PIPE_SKID_EN undefined: capacity 1; in_ready = !out_valid || out_ready (combinational); occ never exceeds 1.

Structure
- REQ-031: NOP_CTRL constant and the rv32i_ctrl_word typedef reside in rv32i_types; no local duplication.
- REQ-032: One sub-module, ctrl_pipe_entry, holds one valid bit + control word + payload with load/clear; instantiated once or twice per configuration.
- REQ-033: stall_cnt logic resides in ctrl_pipe_stage, not in the sub-module.

Verification
- REQ-034: rst for 2 cycles then release -> occ=0, out_valid=0, out_ctrl=NOP_CTRL, stall_cnt=0, in_ready=1.
- REQ-035: Stream 8 entries in_data=1..8, out_ready=1 always -> out_data 1..8 on consecutive cycles, first one cycle after first accept.
- REQ-036: SKID_EN, accept data=0xA, hold out_ready=0, accept 0xB -> occ=2, in_ready=0, stall_cnt increments each cycle; release out_ready -> 0xA then 0xB.
- REQ-037: occ=2 with flush=1 and in_valid=1 (data=0xC) same cycle -> next cycle occ=0, out_valid=0, 0xC never emerges.
- REQ-038: Hold out_valid=1, out_ready=0 for 2^CNT_W+5 cycles with CNT_W=4 -> stall_cnt saturates at 15.
- REQ-039: Skid undefined, out_ready=0, occ=1 -> in_ready=0; set out_ready=1 same cycle with in_valid -> accept and consume both occur, occ stays 1.
